// File: rtl/triad_collector_if.sv
// rtl/triad_collector_if.sv - Result-input and output-FIFO signal bundle for triad_collector
//
// Purpose : groups every non-clock/reset signal of triad_collector.
// Macro   : TRIAD_COLLECTOR_TIMESTAMP_EN widens out_data by TS_WIDTH.
// Signals :
//   triad_ready [NUM_TRIADS]        per-source single-cycle result strobe
//   triad_data  [NUM_TRIADS*DATA_W] slice i = {pulse_id_2, pulse_id_1, pulse_id_0, polynomial}
//   sys_ts      [TS_WIDTH]          free-running system timestamp
//   out_ready                       consumer accepts the head word
//   out_valid                       head word present
//   out_data    [OUT_W]             {[captured ts], source index, triad data}
//   fifo_level  [LVL_W]             words stored
//   drop_count  [16]                overwritten results, saturating
//   state_led                       any source pending or FIFO non-empty
// Modports: master = producer/consumer side, slave = collector side.

interface triad_collector_if #(
   parameter int NUM_TRIADS = 4,
   parameter int FIFO_DEPTH = 16,
   parameter int ID_WIDTH   = 17,
   parameter int TS_WIDTH   = 24
);
   localparam int IDX_W  = (NUM_TRIADS > 1) ? $clog2(NUM_TRIADS) : 1;
   localparam int DATA_W = 4 * ID_WIDTH;
   localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
`ifdef TRIAD_COLLECTOR_TIMESTAMP_EN
   localparam int OUT_W  = TS_WIDTH + IDX_W + DATA_W;
`else
   localparam int OUT_W  = IDX_W + DATA_W;
`endif

   logic [NUM_TRIADS-1:0]        triad_ready;
   logic [NUM_TRIADS*DATA_W-1:0] triad_data;
   logic [TS_WIDTH-1:0]          sys_ts;
   logic                         out_ready;
   logic                         out_valid;
   logic [OUT_W-1:0]             out_data;
   logic [LVL_W-1:0]             fifo_level;
   logic [15:0]                  drop_count;
   logic                         state_led;

   modport master (
      output triad_ready, triad_data, sys_ts, out_ready,
      input  out_valid, out_data, fifo_level, drop_count, state_led
   );

   modport slave (
      input  triad_ready, triad_data, sys_ts, out_ready,
      output out_valid, out_data, fifo_level, drop_count, state_led
   );
endinterface

// File: rtl/triad_collector.sv
// rtl/triad_collector.sv - Per-source result slots, round-robin arbiter and output FIFO
//
// Purpose : captures triad results from NUM_TRIADS sources into one pending slot
//           each, grants one slot per cycle round-robin into a FIFO_DEPTH output
//           FIFO, and counts results lost to slot overwrite.
// Macro   : TRIAD_COLLECTOR_TIMESTAMP_EN adds sys_ts capture per slot and places
//           it in the top TS_WIDTH bits of each output word.
// Ports   :
//   clk_96MHz  in   sole clock, rising edge
//   reset      in   synchronous, active-high
//   bus        slave modport of triad_collector_if (strobes, data, ts, output FIFO)

module triad_collector #(
   parameter int NUM_TRIADS = 4,
   parameter int FIFO_DEPTH = 16,
   parameter int ID_WIDTH   = 17,
   parameter int TS_WIDTH   = 24
) (
   input  logic             clk_96MHz,
   input  logic             reset,
   triad_collector_if.slave bus
);
   localparam int IDX_W  = (NUM_TRIADS > 1) ? $clog2(NUM_TRIADS) : 1;
   localparam int DATA_W = 4 * ID_WIDTH;
   localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
`ifdef TRIAD_COLLECTOR_TIMESTAMP_EN
   localparam int OUT_W  = TS_WIDTH + IDX_W + DATA_W;
`else
   localparam int OUT_W  = IDX_W + DATA_W;
`endif

   logic [NUM_TRIADS-1:0] r_pend;
   logic [DATA_W-1:0]     r_slot_data [NUM_TRIADS];
`ifdef TRIAD_COLLECTOR_TIMESTAMP_EN
   logic [TS_WIDTH-1:0]   r_slot_ts   [NUM_TRIADS];
`else
   logic                  w_unused_ts;
`endif
   logic [OUT_W-1:0]      r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [LVL_W-1:0]      r_level;
   logic [15:0]           r_drop;
   logic [IDX_W-1:0]      r_rr_ptr;   // highest-priority index for the next grant

   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_gnt_any;
   logic [IDX_W-1:0]      w_gnt_idx;
   logic [OUT_W-1:0]      w_word;
   logic [16:0]           w_drop_n;
   logic [16:0]           w_drop_sum;

   // k-th candidate in round-robin order starting at base, wrapping at NUM_TRIADS
   function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NUM_TRIADS) s = s - NUM_TRIADS;
      return IDX_W'(s);
   endfunction

   assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
   assign w_empty = (r_level == '0);
   // Fullness is judged on the registered level, so a same-cycle pop never frees room
   assign w_push  = w_gnt_any && !w_full;
   assign w_pop   = !w_empty && bus.out_ready;

   always_comb begin
      w_gnt_any = 1'b0;
      w_gnt_idx = '0;
      for (int k = 0; k < NUM_TRIADS; k++) begin
         if (!w_gnt_any && r_pend[rr_index(r_rr_ptr, k)]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = rr_index(r_rr_ptr, k);
         end
      end
   end

`ifdef TRIAD_COLLECTOR_TIMESTAMP_EN
   assign w_word = {r_slot_ts[w_gnt_idx], w_gnt_idx, r_slot_data[w_gnt_idx]};
`else
   assign w_word = {w_gnt_idx, r_slot_data[w_gnt_idx]};
   assign w_unused_ts = ^bus.sys_ts;
`endif

   // A strobe onto a pending slot loses the old result unless that slot is
   // being pushed this very cycle.
   always_comb begin
      w_drop_n = '0;
      for (int i = 0; i < NUM_TRIADS; i++) begin
         if (bus.triad_ready[i] && r_pend[i] && !(w_push && w_gnt_idx == IDX_W'(i)))
            w_drop_n = w_drop_n + 17'd1;
      end
      w_drop_sum = {1'b0, r_drop} + w_drop_n;
   end

   always_ff @(posedge clk_96MHz) begin
      if (reset) begin
         r_pend <= '0;
      end else begin
         for (int i = 0; i < NUM_TRIADS; i++) begin
            if (bus.triad_ready[i]) begin
               r_pend[i]      <= 1'b1;
               r_slot_data[i] <= bus.triad_data[i*DATA_W +: DATA_W];
`ifdef TRIAD_COLLECTOR_TIMESTAMP_EN
               r_slot_ts[i]   <= bus.sys_ts;
`endif
            end else if (w_push && w_gnt_idx == IDX_W'(i)) begin
               r_pend[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk_96MHz) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_drop   <= '0;
         r_rr_ptr <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            r_rr_ptr <= (w_gnt_idx == IDX_W'(NUM_TRIADS - 1)) ? '0 : w_gnt_idx + IDX_W'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
         r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      end
   end

   always_ff @(posedge clk_96MHz) begin
      if (w_push) r_mem[r_wr_ptr] <= w_word;
   end

   assign bus.out_valid  = !w_empty;
   assign bus.out_data   = r_mem[r_rd_ptr];
   assign bus.fifo_level = r_level;
   assign bus.drop_count = r_drop;
   assign bus.state_led  = (|r_pend) || !w_empty;
endmodule
